// File: rtl/dm_pkg.sv
// Shared constants and word type for the data memory.
package dm_pkg;

  localparam int unsigned DM_DATA_W = 32;
  localparam int unsigned DM_DEPTH  = 256;
  localparam int unsigned DM_ADDR_W = 32;

  typedef logic [DM_DATA_W-1:0] dm_word_t;

endpackage : dm_pkg

// File: rtl/data_memory.sv
// Word-addressed register-array data memory: synchronous write and clear, combinational read.
module data_memory
  import dm_pkg::*;
#(
  parameter int unsigned DATA_W = DM_DATA_W,
  parameter int unsigned DEPTH  = DM_DEPTH,
  parameter int unsigned ADDR_W = DM_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] adress,
  output logic [DATA_W-1:0] rdata,
  input  logic [DATA_W-1:0] wdata,
  input  logic              MemWrite,
  input  logic              MemRead,
  output logic              addr_err
);

  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  // One extra bit so DEPTH itself is representable even when DEPTH == 2**ADDR_W.
  localparam logic [ADDR_W:0] LP_DEPTH = (ADDR_W + 1)'(DEPTH);

  logic [DATA_W-1:0] r_mem [DEPTH];

  logic             w_in_range;
  logic [IDX_W-1:0] w_idx;

  assign w_in_range = ({1'b0, adress} < LP_DEPTH);
  assign w_idx      = adress[IDX_W-1:0];
  assign addr_err   = (MemRead | MemWrite) & ~w_in_range;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_mem[IDX_W'(i)] <= '0;
      end
    end else if (MemWrite && w_in_range) begin
      r_mem[w_idx] <= wdata;
    end
  end

  always_comb begin
    rdata = '0;
    if (MemRead && w_in_range) begin
      rdata = r_mem[w_idx];
    end
  end

endmodule : data_memory

// File: tb/tb_data_memory.sv
// Directed self-checking bench for data_memory.
module tb_data_memory;
  import dm_pkg::*;

  logic     clk;
  logic     rst_n;
  logic [31:0] adress;
  dm_word_t rdata;
  dm_word_t wdata;
  logic     MemWrite;
  logic     MemRead;
  logic     addr_err;

  int checks = 0;
  int errors = 0;

  data_memory #(
    .DATA_W(32),
    .DEPTH (256),
    .ADDR_W(32)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .adress  (adress),
    .rdata   (rdata),
    .wdata   (wdata),
    .MemWrite(MemWrite),
    .MemRead (MemRead),
    .addr_err(addr_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d);
    MemRead  = rd;
    MemWrite = wr;
    adress   = a;
    wdata    = d;
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    drive(1'b1, 1'b0, 32'd0, 32'h0);
    tick();
    check("reset_rd0_during_rst", rdata, 32'h0);
    check("reset_err_during_rst", {31'b0, addr_err}, 32'h0);
    tick();
    rst_n = 1'b1;

    // Post-reset reads
    drive(1'b1, 1'b0, 32'd0, 32'h0);   check("rst_rd_a0", rdata, 32'h0);
    drive(1'b1, 1'b0, 32'd1, 32'h0);   check("rst_rd_a1", rdata, 32'h0);
    drive(1'b1, 1'b0, 32'd7, 32'h0);   check("rst_rd_a7", rdata, 32'h0);
    drive(1'b1, 1'b0, 32'd15, 32'h0);  check("rst_rd_a15", rdata, 32'h0);
    drive(1'b1, 1'b0, 32'd255, 32'h0); check("rst_rd_a255", rdata, 32'h0);
    check("rst_err_a255", {31'b0, addr_err}, 32'h0);

    // Write phase
    drive(1'b0, 1'b1, 32'd1, 32'h00000008); tick();
    drive(1'b0, 1'b1, 32'd7, 32'h00000009); tick();
    drive(1'b1, 1'b0, 32'd1, 32'h0);  check("rb_a1", rdata, 32'h00000008);
    drive(1'b1, 1'b0, 32'd7, 32'h0);  check("rb_a7", rdata, 32'h00000009);
    drive(1'b1, 1'b0, 32'd15, 32'h0); check("rb_a15", rdata, 32'h00000000);
    drive(1'b1, 1'b0, 32'd0, 32'h0);  check("rb_a0", rdata, 32'h00000000);

    // Last word and out-of-range
    drive(1'b0, 1'b1, 32'd255, 32'hDEADBEEF);
    check("wr255_err", {31'b0, addr_err}, 32'h0);
    tick();
    drive(1'b1, 1'b0, 32'd255, 32'h0); check("rb_a255", rdata, 32'hDEADBEEF);
    drive(1'b0, 1'b1, 32'd256, 32'hCAFEF00D);
    check("wr256_err", {31'b0, addr_err}, 32'h1);
    tick();
    drive(1'b1, 1'b0, 32'd256, 32'h0);
    check("rd256_err", {31'b0, addr_err}, 32'h1);
    check("rd256_data", rdata, 32'h0);
    drive(1'b1, 1'b0, 32'd0, 32'h0);   check("rd_a0_after_oob", rdata, 32'h0);
    drive(1'b0, 1'b0, 32'd256, 32'h0); check("idle256_err", {31'b0, addr_err}, 32'h0);
    drive(1'b0, 1'b1, 32'h80000001, 32'h55555555);
    check("wr_hi_err", {31'b0, addr_err}, 32'h1);
    tick();
    drive(1'b1, 1'b0, 32'd1, 32'h0);   check("rd_a1_after_hi", rdata, 32'h00000008);
    drive(1'b1, 1'b0, 32'd255, 32'h0); check("rd_a255_after_oob", rdata, 32'hDEADBEEF);

    // Same-address read and write
    drive(1'b1, 1'b1, 32'd7, 32'h12345678);
    check("rw_same_before", rdata, 32'h00000009);
    tick();
    check("rw_same_after", rdata, 32'h12345678);
    drive(1'b1, 1'b0, 32'd1, 32'h0);   check("rw_other_word", rdata, 32'h00000008);

    // Read disabled
    drive(1'b0, 1'b0, 32'd1, 32'h0);
    check("rd_off_data", rdata, 32'h0);
    check("rd_off_err", {31'b0, addr_err}, 32'h0);

    // Reset mid-sequence; the write on the reset edge is dropped
    rst_n = 1'b0;
    drive(1'b0, 1'b1, 32'd2, 32'h0000AAAA);
    tick();
    rst_n = 1'b1;
    drive(1'b1, 1'b0, 32'd1, 32'h0);   check("rst2_a1", rdata, 32'h0);
    drive(1'b1, 1'b0, 32'd7, 32'h0);   check("rst2_a7", rdata, 32'h0);
    drive(1'b1, 1'b0, 32'd2, 32'h0);   check("rst2_a2", rdata, 32'h0);
    drive(1'b1, 1'b0, 32'd255, 32'h0); check("rst2_a255", rdata, 32'h0);

    // Memory is writable again after reset
    drive(1'b0, 1'b1, 32'd15, 32'hA5A5A5A5); tick();
    drive(1'b1, 1'b0, 32'd15, 32'h0);  check("post_rst_wr15", rdata, 32'hA5A5A5A5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_data_memory

// File: doc/data_memory.md
DATA_MEMORY -- requirements
Module: data_memory

Interface
REQ-001 Parameter DATA_W, default 32: word width in bits.
REQ-002 Parameter DEPTH, default 256: number of words stored.
REQ-003 Parameter ADDR_W, default 32: address port width.
REQ-004 Port clk, input, 1 bit: single clock; all state updates occur on its rising edge.
REQ-005 Port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-006 Port adress, input, ADDR_W bits: word address, not a byte address.
REQ-007 Port rdata, output, DATA_W bits: read data.
REQ-008 Port wdata, input, DATA_W bits: write data.
REQ-009 Port MemWrite, input, 1 bit: write enable.
REQ-010 Port MemRead, input, 1 bit: read enable.
REQ-011 Port addr_err, output, 1 bit: high while the current address is out of range and MemRead or MemWrite is high.

Function
REQ-012 Storage SHALL be DEPTH words of DATA_W bits, indexed directly by adress.
- Word n is at adress = n; there is no byte-offset shifting.
REQ-013 An address SHALL be in range iff adress < DEPTH, for the full ADDR_W-bit compare.
REQ-014 Write: on a rising clk edge with rst_n=1, MemWrite=1 and adress in range, mem[adress] SHALL become wdata.
- The written value SHALL be visible in the same edge's update; no other word changes.
REQ-015 A write to an out-of-range address SHALL be discarded, with no aliasing or wrap-around.
REQ-016 Read SHALL be combinational (asynchronous).
- rdata = mem[adress] when MemRead=1 and the address is in range; 0 otherwise.
- Latency is zero cycles from an address or enable change.
REQ-017 Simultaneous read and write to the same address:
- Before the clk edge, rdata shows the old word.
- After the edge, rdata shows wdata, with no extra cycle of latency.
REQ-018 MemRead=1 and MemWrite=1 together SHALL be legal; both operations are performed per REQ-014 and REQ-016.
REQ-019 MemRead=0 and MemWrite=0 SHALL leave memory unchanged and drive rdata=0.
REQ-020 addr_err SHALL be combinational: addr_err = (MemRead | MemWrite) & (adress >= DEPTH).
REQ-021 Inputs are assumed known (not X) on every rising edge where rst_n=1; behaviour with X enables is not specified.

Reset
REQ-022 On a rising clk edge with rst_n=0, every memory word SHALL be cleared to 0.
- Any write requested on that edge SHALL be ignored.
REQ-023 During reset, rdata and addr_err SHALL continue to follow REQ-016 and REQ-020, so rdata reads 0 after the first reset edge.
REQ-024 Reset asserted in the middle of a sequence of writes SHALL discard all previously written data.
REQ-025 Memory contents before the first reset edge are undefined; benches SHALL apply reset before checking reads.

Structure
REQ-026 A shared package dm_pkg SHALL hold the default DATA_W, DEPTH and ADDR_W constants and the word typedef.
REQ-027 The design SHALL be a single module with no sub-modules.
- Implementation: a register-array storage process, one combinational read mux, and the range-check logic.
REQ-028 Storage SHALL be registers, not an inferred vendor RAM, so that full-array synchronous clear is possible.

Verification
REQ-029 Reset, then MemRead=1 at adress=0, 1, 7, 15 and 255 -> rdata=0 at every address; addr_err=0.
REQ-030 Write phase, then read-back:
- Write 0x00000008 to adress=1, then 0x00000009 to adress=7.
- Read with MemRead=1: adress=1 -> 0x00000008; adress=7 -> 0x00000009; adress=15 -> 0x00000000.
REQ-031 Write 0xDEADBEEF to adress=255 (last word), then read -> 0xDEADBEEF.
- Write to adress=256 -> addr_err=1, no write occurs.
- A subsequent read of adress=0 -> 0.
REQ-032 Same-address read and write:
- Hold MemRead=1 at adress=7 with MemWrite=1 and wdata=0x12345678.
- Before the edge, rdata=0x00000009; after the edge, rdata=0x12345678.
REQ-033 Set MemRead=0 with adress=1 -> rdata=0x00000000 and addr_err=0.
REQ-034 Assert rst_n=0 for one edge after the writes above, then read adress=1 and adress=7 -> 0x00000000 at both.
